// File: rtl/rc_pkg.sv
// Shared definitions for the permutation-core host driver: FSM states and block sizing.
package rc_pkg;

    localparam int RC_N_BITS     = 254;
    localparam int RC_NUM_ELEMS  = 39;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEV_RST = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RUN     = 3'd3,
        ST_UNLOAD  = 3'd4
    } rc_state_e;

endpackage

// File: rtl/rc_skid_fifo.sv
// Two-entry output FIFO; a push and a pop in the same cycle leave the occupancy unchanged.
module rc_skid_fifo #(
    parameter int WIDTH = 254
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && (count != 2'd0);
    assign do_push   = push && (count != 2'd2 || do_pop);
    assign head      = mem[rd_ptr];
    assign not_empty = (count != 2'd0);

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/rc_host_driver.sv
// Host-side sequencer: resets the permutation core, streams a block in, runs it,
// and unloads the results through a 2-entry FIFO onto the downstream stream.
//
// state      | meaning
// IDLE       | waiting for the first beat of a block (not accepted here)
// DEV_RST    | one-cycle rc_reset pulse to rewind core pointers
// LOAD       | forwarding NUM_ELEMS upstream beats to the core
// RUN        | rc_enable high until the core reports done
// UNLOAD     | reading results into the FIFO and draining it downstream
module rc_host_driver
    import rc_pkg::*;
#(
    parameter int N_BITS    = RC_N_BITS,
    parameter int NUM_ELEMS = RC_NUM_ELEMS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_BITS-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [N_BITS-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [N_BITS-1:0] rc_in_state,
    output logic              rc_wr,
    output logic              rc_rd,
    output logic              rc_enable,
    output logic              rc_reset,
    input  logic [N_BITS-1:0] rc_out_state,
    input  logic              rc_done,
    output logic              busy
);

    localparam int            CW       = $clog2(NUM_ELEMS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_ELEMS - 1);
    localparam logic [CW-1:0] CNT_ALL  = CW'(NUM_ELEMS);

    rc_state_e     state;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] out_cnt;
    logic          rd_q;
    logic          pop;
    logic [1:0]    fifo_count;
    logic [2:0]    pending;

    assign s_ready     = (state == ST_LOAD);
    assign rc_wr       = s_ready && s_valid;
    assign rc_in_state = s_data;
    assign busy        = (state != ST_IDLE);
    assign pop         = m_valid && m_ready;

    // Slots already spoken for after this cycle's pop; keeps the FIFO from overflowing
    // while still allowing one read per cycle when the consumer keeps up.
    assign pending = {1'b0, fifo_count} + {2'b00, rd_q} - {2'b00, pop};
    assign rc_rd   = (state == ST_UNLOAD) && (rd_cnt < CNT_ALL) && (pending < 3'd2);
    assign m_last  = m_valid && (out_cnt == CNT_LAST);

    rc_skid_fifo #(.WIDTH(N_BITS)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rd_q),
        .push_data (rc_out_state),
        .pop       (pop),
        .head      (m_data),
        .not_empty (m_valid),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rc_reset  <= 1'b1;
            rc_enable <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            out_cnt   <= '0;
            rd_q      <= 1'b0;
        end else begin
            rc_reset <= 1'b0;
            rd_q     <= rc_rd;
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        state    <= ST_DEV_RST;
                        rc_reset <= 1'b1;
                    end
                end
                ST_DEV_RST: begin
                    state   <= ST_LOAD;
                    wr_cnt  <= '0;
                    rd_cnt  <= '0;
                    out_cnt <= '0;
                end
                ST_LOAD: begin
                    if (rc_wr) begin
                        wr_cnt <= wr_cnt + CW'(1);
                        if (wr_cnt == CNT_LAST) begin
                            state     <= ST_RUN;
                            rc_enable <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rc_done) begin
                        state     <= ST_UNLOAD;
                        rc_enable <= 1'b0;
                    end
                end
                ST_UNLOAD: begin
                    if (rc_rd) rd_cnt <= rd_cnt + CW'(1);
                    if (pop) begin
                        out_cnt <= out_cnt + CW'(1);
                        if (m_last) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rc_host_driver.sv
// Directed bench for rc_host_driver with a behavioural core stub (result = input + 5).
module tb_rc_host_driver;

    localparam int NB  = 254;
    localparam int NE  = 39;
    localparam int ADD = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [NB-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_last;
    logic [NB-1:0] rc_in_state;
    logic          rc_wr, rc_rd, rc_enable, rc_reset, rc_done, busy;
    logic [NB-1:0] rc_out_state = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rc_host_driver #(.N_BITS(NB), .NUM_ELEMS(NE)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .rc_in_state(rc_in_state), .rc_wr(rc_wr), .rc_rd(rc_rd),
        .rc_enable(rc_enable), .rc_reset(rc_reset),
        .rc_out_state(rc_out_state), .rc_done(rc_done), .busy(busy)
    );

    // core stub: serial load/unload memory, registered read data, done 10 cycles into enable
    logic [NB-1:0] mem [64];
    logic [5:0]    wp = '0, rp = '0;
    int            en_cnt = 0;
    always @(posedge clk) begin
        if (rc_reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (rc_wr) begin mem[wp] <= rc_in_state; wp <= wp + 6'd1; end
            if (rc_rd) begin rc_out_state <= mem[rp] + NB'(ADD); rp <= rp + 6'd1; end
        end
        en_cnt <= rc_enable ? en_cnt + 1 : 0;
    end
    assign rc_done = rc_enable && (en_cnt == 10);

    // monitors sample mid-cycle, when every handshake signal is settled
    int            cyc = 0;
    int            n_wr = 0, n_rd = 0, n_both = 0, n_rst_hi = 0, n_rst_rise = 0;
    int            wr_at_en = -1, n_unstable = 0;
    logic          en_q = 1'b0, rst_q = 1'b0, hold_v = 1'b0, hold_l = 1'b0;
    logic [NB-1:0] hold_d = '0;
    logic [NB-1:0] out_data[$];
    logic          out_last[$];
    int            out_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (rc_wr) n_wr++;
            if (rc_rd) n_rd++;
            if (rc_wr && rc_rd) n_both++;
            if (rc_reset) n_rst_hi++;
            if (rc_reset && !rst_q) n_rst_rise++;
            if (rc_enable && !en_q) wr_at_en = n_wr;
            if (hold_v && (!m_valid || m_data != hold_d || m_last != hold_l)) n_unstable++;
            if (m_valid && m_ready) begin
                out_data.push_back(m_data);
                out_last.push_back(m_last);
                out_cyc.push_back(cyc);
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
        end
        en_q  = rc_enable;
        rst_q = rc_reset;
    end

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // drives beats base..base+nbeats-1; toggle inserts an idle cycle between offers
    task automatic send(input int base, input bit toggle, input int nbeats);
        int  idx = 0;
        int  guard = 0;
        bit  phase = 1'b1;
        bit  acc;
        while (idx < nbeats && guard < 400) begin
            s_valid = toggle ? phase : 1'b1;
            s_data  = NB'(base + idx);
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            phase = ~phase;
            guard++;
        end
        s_valid = 1'b0;
        check("send_timeout", NB'(idx), NB'(nbeats));
    endtask

    task automatic wait_outputs(input int target);
        int guard = 0;
        while (out_data.size() < target && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check("out_timeout", NB'(out_data.size() >= target), NB'(1));
    endtask

    task automatic check_block(input string tag, input int ob, input int base, input bit gaps);
        int max_gap = 0;
        for (int i = 0; i < NE; i++) begin
            check($sformatf("%s_data%0d", tag, i), out_data[ob+i], NB'(base + i + ADD));
            check($sformatf("%s_last%0d", tag, i), NB'(out_last[ob+i]), NB'(i == NE - 1));
            if (i > 0 && out_cyc[ob+i] - out_cyc[ob+i-1] > max_gap)
                max_gap = out_cyc[ob+i] - out_cyc[ob+i-1];
        end
        if (gaps) check({tag, "_max_gap"}, NB'(max_gap), NB'(1));
    endtask

    task automatic run_block(input string tag, input int base, input bit toggle);
        int ob  = out_data.size();
        int w0  = n_wr;
        int r0  = n_rd;
        int rh0 = n_rst_hi;
        send(base, toggle, NE);
        wait_outputs(ob + NE);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_wr"}, NB'(n_wr - w0), NB'(NE));
        check({tag, "_rd"}, NB'(n_rd - r0), NB'(NE));
        check({tag, "_en_after"}, NB'(wr_at_en - w0), NB'(NE));
        check({tag, "_rst_cycles"}, NB'(n_rst_hi - rh0), NB'(1));
        check({tag, "_nout"}, NB'(out_data.size() - ob), NB'(NE));
        check({tag, "_busy_end"}, NB'(busy), NB'(0));
        check_block(tag, ob, base, m_ready);
    endtask

    initial begin
        int ob, r0, rr0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", NB'(busy), NB'(0));
        check("rst_rc_reset", NB'(rc_reset), NB'(1));
        check("rst_s_ready", NB'(s_ready), NB'(0));
        check("rst_m_valid", NB'(m_valid), NB'(0));
        check("rst_rc_enable", NB'(rc_enable), NB'(0));
        check("rst_strobes", NB'({rc_wr, rc_rd, m_last}), NB'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rel_rc_reset", NB'(rc_reset), NB'(0));

        // back-to-back beats, consumer always ready
        run_block("b2b", 1, 1'b0);

        // upstream valid toggles every cycle
        run_block("tog", 50, 1'b1);

        // consumer stalls 20 cycles at start of unload
        m_ready = 1'b0;
        ob = out_data.size();
        r0 = n_rd;
        send(300, 1'b0, NE);
        begin
            int guard = 0;
            while (!m_valid && guard < 100) begin @(posedge clk); #1; guard++; end
            check("stall_reach_unload", NB'(m_valid), NB'(1));
        end
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("stall_rd_le2", NB'((n_rd - r0) <= 2), NB'(1));
        check("stall_head", m_data, NB'(300 + ADD));
        check("stall_no_out", NB'(out_data.size() - ob), NB'(0));
        check("stall_stable", NB'(n_unstable), NB'(0));
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_outputs(ob + NE);
        check_block("stall", ob, 300, 1'b0);

        // reset mid-load after 17 beats
        ob = out_data.size();
        send(400, 1'b0, 17);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_busy", NB'(busy), NB'(0));
        check("mid_rc_reset", NB'(rc_reset), NB'(1));
        check("mid_s_ready", NB'(s_ready), NB'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_rc_reset", NB'(rc_reset), NB'(0));
        check("mid_no_out", NB'(out_data.size() - ob), NB'(0));
        run_block("post_rst", 500, 1'b0);

        // two blocks back-to-back: one rc_reset pulse each, independent results
        rr0 = n_rst_rise;
        run_block("blkA", 600, 1'b0);
        run_block("blkB", 700, 1'b0);
        check("two_rst_pulses", NB'(n_rst_rise - rr0), NB'(2));

        check("no_wr_rd_overlap", NB'(n_both), NB'(0));
        check("no_unstable", NB'(n_unstable), NB'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rc_host_driver.md
RC_HOST_DRIVER -- requirements
Module: rc_host_driver

Interface
REQ-001 SHALL have parameter N_BITS, default 254, giving the field-element width.
REQ-002 SHALL have parameter NUM_ELEMS, default 39 (3 state words x 13 lanes), giving the elements per block.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports s_data (input, N_BITS), s_valid (input, 1) and s_ready (output, 1): the upstream element stream.
REQ-006 SHALL have ports m_data (output, N_BITS), m_valid (output, 1), m_ready (input, 1) and m_last (output, 1): the downstream result stream.
REQ-007 SHALL have ports rc_in_state (output, N_BITS), rc_wr (output, 1) and rc_rd (output, 1): write data and strobes to the permutation core's serial load/unload port.
REQ-008 SHALL have ports rc_enable (output, 1) and rc_reset (output, 1, active-high): run enable and pointer reset to the core.
REQ-009 SHALL have ports rc_out_state (input, N_BITS) and rc_done (input, 1): core read data and completion flag.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 SHALL implement a state machine with states IDLE, DEV_RST, LOAD, RUN and UNLOAD.
REQ-012 SHALL leave IDLE for DEV_RST when s_valid=1, without accepting that beat.
REQ-013 SHALL assert rc_reset for exactly 1 cycle in DEV_RST, then enter LOAD, so the core's write and read pointers restart at 0 for each block.
REQ-014 SHALL, in LOAD, drive s_ready=1 and rc_wr=s_valid with rc_in_state=s_data, and count accepted beats; s_ready SHALL be 0 in all other states.
REQ-015 SHALL enter RUN on the cycle after the NUM_ELEMS-th beat is accepted, with rc_wr never asserted more than NUM_ELEMS times per block.
REQ-016 SHALL, in RUN, hold rc_enable=1 until rc_done is sampled high, then drop rc_enable and enter UNLOAD on the next cycle.
REQ-017 SHALL never assert rc_wr and rc_rd in the same cycle.
REQ-018 SHALL issue rc_rd in UNLOAD only while reads issued < NUM_ELEMS and (output FIFO occupancy + reads in flight) < 2.
REQ-019 SHALL capture rc_out_state into a 2-entry output FIFO exactly 1 cycle after each rc_rd, since core read data is registered.
REQ-020 SHALL present the FIFO head on m_data with m_valid=1 when the FIFO is not empty, and pop it when m_valid and m_ready are both 1.
REQ-021 SHALL count a push and a pop in the same cycle as a net-zero change in occupancy.
REQ-022 SHALL sustain 1 element per cycle while m_ready stays high, after the first 2-cycle fill latency.
REQ-023 SHALL assert m_last with the NUM_ELEMS-th output beat.
REQ-024 SHALL return to IDLE on the cycle after the m_last beat pops.
REQ-025 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.

Reset
REQ-026 SHALL, on reset_n low (asynchronous), force state=IDLE, all counters=0, FIFO empty, m_valid=0, m_last=0, s_ready=0, rc_wr=0, rc_rd=0, rc_enable=0, busy=0 and rc_reset=1.
REQ-027 SHALL deassert rc_reset on the first clock edge after reset_n is released, so the core is cleared by any reset mid-operation.
REQ-028 SHALL discard a block that is partially loaded or unloaded when reset is applied, with no output beats emitted for it.

Structure
REQ-029 SHALL take its state enum and NUM_ELEMS default from the shared rc_pkg package.
REQ-030 SHALL implement the 2-entry output FIFO as the sub-module rc_skid_fifo (parameter WIDTH).

Verification
REQ-031 SHALL cover: 39 back-to-back beats 1..39, core stub asserting done 10 cycles after enable -> 39 rc_wr, then 39 outputs in order with m_last on beat 39 only.
REQ-032 SHALL cover: s_valid toggling 1/0 on every cycle -> exactly 39 rc_wr, and rc_enable rising only after the 39th beat.
REQ-033 SHALL cover: m_ready held 0 for 20 cycles in UNLOAD -> at most 2 rc_rd issued, m_data stable, no beats lost.
REQ-034 SHALL cover: m_ready held 1 throughout -> output beats on consecutive cycles after the first.
REQ-035 SHALL cover: reset_n pulsed low after 17 loaded beats -> IDLE, rc_reset high, and a following full block correct.
REQ-036 SHALL cover: two blocks back-to-back -> a 1-cycle rc_reset pulse before each LOAD, and the second block's results independent of the first.
